// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a requester and the PS/2 host transmitter.
// The master offers a byte with valid/ready and observes done/err/busy.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_err,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_err,
        output busy
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Pulls open-collector PS2_CLK/PS2_DAT low, checks the device ACK, bounds transfer time.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave tx_if,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_s, data_s;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          doe_q, doe_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [9:0]    frame;
    logic          tout_hit;

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign frame    = {1'b1, par_q, data_q};
    assign tout_hit = (tout_q == TW'(TIMEOUT_CYCLES));

    // Two-flop synchronizers; lines idle high so reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    // Clock glitch filter: level follows only a run of FILTER_LEN equal samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    // Filter state and registered falling-edge strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
        end
    end

    // Transfer sequencer state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            inh_q   <= '0;
            tout_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            doe_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inh_d;
            tout_q  <= tout_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            par_q   <= par_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next-state: inhibit, start bit, device-clocked shift, ACK, line-idle wait.
    always_comb begin
        state_d = state_q;
        inh_d   = inh_q;
        tout_d  = tout_q;
        bit_d   = bit_q;
        data_d  = data_q;
        par_d   = par_q;
        doe_d   = doe_q;
        ack_d   = ack_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (tx_if.tx_valid) begin
                    data_d  = tx_if.tx_data;
                    par_d   = ~^tx_if.tx_data;
                    inh_d   = '0;
                    err_d   = 1'b0;
                    doe_d   = 1'b0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    doe_d   = 1'b1;
                    state_d = S_START;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            S_START: begin
                tout_d  = '0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT, S_ACK, S_WAIT: begin
                if (tout_hit) begin
                    doe_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tout_d = tout_q + 1'b1;
                    if (state_q == S_SHIFT && fall_q) begin
                        doe_d = ~frame[bit_q];
                        if (bit_q == 4'd9) begin
                            state_d = S_ACK;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else if (state_q == S_ACK && fall_q) begin
                        ack_d   = data_s;
                        state_d = S_WAIT;
                    end else if (state_q == S_WAIT && filt_q && data_s) begin
                        err_d   = ack_q;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_if.tx_ready = (state_q == S_IDLE);
    assign tx_if.busy     = (state_q != S_IDLE);
    assign tx_if.tx_done  = (state_q == S_DONE);
    assign tx_if.tx_err   = err_q;
    assign ps2_clk_oe     = (state_q == S_INHIBIT) || (state_q == S_START);
    assign ps2_data_oe    = doe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for the PS/2 host transmitter.
// A behavioural keyboard clocks frames out of the DUT and answers with ACK or not.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int TOUT = 3000;
    localparam int FILT = 8;
    localparam int HP   = 30;
    localparam int NV   = 7;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    int   n_cmp        = 0;
    int   n_bad        = 0;
    int   done_cnt     = 0;
    logic last_err     = 1'b0;
    logic drop_on_done = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic [10:0] exp_bits;
        logic        exp_err;
        int          glitch;
        logic        hold;
    } vec_t;

    typedef struct {
        logic [10:0] bits;
        int          inh_len;
        int          overlap;
        logic        first_ready;
        logic        first_cloe;
        logic        first_busy;
        logic        released;
        logic        done_seen;
        logic        err;
        logic        ready_after;
        logic        glitch_ok;
    } res_t;

    vec_t tbl [NV];
    res_t r;

    ps2_host_tx_if tx ();

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TOUT),
        .FILTER_LEN(FILT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_if(tx),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next sampling point and log any done pulse there.
    task automatic tick();
        @(negedge clk);
        if (tx.tx_done === 1'b1) begin
            done_cnt++;
            last_err = tx.tx_err;
            if (drop_on_done) tx.tx_valid = 1'b0;
        end
    endtask

    task automatic device_xfer(input logic ack, input int glitch_at, input logic hold,
                               output res_t o);
        logic snap;
        int   guard;
        int   d0;
        snap          = 1'b0;
        o.bits        = '0;
        o.inh_len     = 0;
        o.overlap     = 0;
        o.done_seen   = 1'b0;
        o.err         = 1'b0;
        o.ready_after = 1'b0;
        o.glitch_ok   = 1'b1;
        d0            = done_cnt;
        tick();
        o.first_ready = tx.tx_ready;
        o.first_cloe  = ps2_clk_oe;
        o.first_busy  = tx.busy;
        if (!hold) tx.tx_valid = 1'b0;
        guard = 0;
        while (ps2_clk_oe && guard < 4 * INH) begin
            o.inh_len++;
            if (ps2_data_oe) o.overlap++;
            tick();
            guard++;
        end
        o.released = !ps2_clk_oe;
        o.bits[0]  = ps2_data_in;
        repeat (HP) tick();
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (HP) tick();
            if (i <= 10) o.bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            for (int j = 0; j < HP; j++) begin
                tick();
                if (i == glitch_at) begin
                    if (j == 15) begin
                        snap    = ps2_data_oe;
                        dev_clk = 1'b0;
                    end
                    if (j == 18) dev_clk = 1'b1;
                    if (j > 15 && ps2_data_oe !== snap) o.glitch_ok = 1'b0;
                end
            end
            if (i == 11) dev_data = 1'b1;
        end
        guard = 0;
        while (done_cnt == d0 && guard < 200) begin
            tick();
            guard++;
        end
        o.done_seen = (done_cnt == d0 + 1);
        o.err       = last_err;
        tick();
        o.ready_after = tx.tx_ready;
    endtask

    initial begin
        int guard;
        int k;
        int d0;
        int extra;
        logic prev_oe;

        tbl[0] = '{8'hED, 1'b1, 11'b11111011010, 1'b0, 0, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 11'b10000000010, 1'b0, 0, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 11'b11111111110, 1'b0, 0, 1'b0};
        tbl[3] = '{8'hF4, 1'b0, 11'b10111101000, 1'b1, 0, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 11'b11000000000, 1'b0, 0, 1'b0};
        tbl[5] = '{8'hA5, 1'b1, 11'b11101001010, 1'b0, 3, 1'b0};
        tbl[6] = '{8'h3C, 1'b1, 11'b11001111000, 1'b0, 0, 1'b1};

        tx.tx_data  = 8'h00;
        tx.tx_valid = 1'b0;

        repeat (3) tick();
        check("rst_ready", tx.tx_ready, 1);
        check("rst_done", tx.tx_done, 0);
        check("rst_err", tx.tx_err, 0);
        check("rst_busy", tx.busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_ready", tx.tx_ready, 1);

        for (int i = 0; i < NV; i++) begin
            tx.tx_data   = tbl[i].data;
            tx.tx_valid  = 1'b1;
            drop_on_done = tbl[i].hold;
            device_xfer(tbl[i].ack, tbl[i].glitch, tbl[i].hold, r);
            check($sformatf("v%0d_accept_ready", i), r.first_ready, 0);
            check($sformatf("v%0d_accept_clk_oe", i), r.first_cloe, 1);
            check($sformatf("v%0d_busy", i), r.first_busy, 1);
            check($sformatf("v%0d_inhibit_len", i), r.inh_len, INH + 1);
            check($sformatf("v%0d_start_overlap", i), r.overlap, 1);
            check($sformatf("v%0d_released", i), r.released, 1);
            check($sformatf("v%0d_frame", i), r.bits, tbl[i].exp_bits);
            check($sformatf("v%0d_done", i), r.done_seen, 1);
            check($sformatf("v%0d_err", i), r.err, tbl[i].exp_err);
            check($sformatf("v%0d_ready_after", i), r.ready_after, 1);
            if (tbl[i].glitch > 0) begin
                check($sformatf("v%0d_glitch_hold", i), r.glitch_ok, 1);
            end
            if (tbl[i].hold) begin
                d0    = done_cnt;
                extra = 0;
                repeat (60) begin
                    tick();
                    if (ps2_clk_oe || !tx.tx_ready) extra++;
                end
                check($sformatf("v%0d_single_xfer", i), extra, 0);
                check($sformatf("v%0d_no_extra_done", i), done_cnt - d0, 0);
            end
        end
        drop_on_done = 1'b0;

        // Device never clocks: transfer must time out.
        tx.tx_data  = 8'h12;
        tx.tx_valid = 1'b1;
        tick();
        tx.tx_valid = 1'b0;
        guard = 0;
        while (ps2_clk_oe && guard < 4 * INH) begin
            tick();
            guard++;
        end
        check("tout_release", ps2_clk_oe, 0);
        d0      = done_cnt;
        k       = 0;
        prev_oe = ps2_data_oe;
        while (done_cnt == d0 && k < TOUT + 100) begin
            prev_oe = ps2_data_oe;
            tick();
            k++;
        end
        check("tout_cycles", k, TOUT + 1);
        check("tout_oe_before", prev_oe, 1);
        check("tout_oe_after", ps2_data_oe, 0);
        check("tout_err", last_err, 1);
        repeat (5) tick();
        check("tout_err_hold", tx.tx_err, 1);
        check("tout_ready", tx.tx_ready, 1);

        // Reset while the clock line is inhibited.
        tx.tx_data  = 8'h55;
        tx.tx_valid = 1'b1;
        tick();
        tx.tx_valid = 1'b0;
        repeat (10) tick();
        check("rst_inh_pre_clk_oe", ps2_clk_oe, 1);
        reset = 1'b1;
        #1;
        check("rst_inh_clk_oe", ps2_clk_oe, 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Reset after the fourth device falling edge.
        tx.tx_data  = 8'hF4;
        tx.tx_valid = 1'b1;
        tick();
        tx.tx_valid = 1'b0;
        guard = 0;
        while (ps2_clk_oe && guard < 4 * INH) begin
            tick();
            guard++;
        end
        repeat (HP) tick();
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0;
            repeat (HP) tick();
            if (i < 4) begin
                dev_clk = 1'b1;
                repeat (HP) tick();
            end
        end
        check("rst_mid_pre_data_oe", ps2_data_oe, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_clk_oe", ps2_clk_oe, 0);
        check("rst_mid_data_oe", ps2_data_oe, 0);
        check("rst_mid_busy", tx.busy, 0);
        dev_clk = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_mid_ready", tx.tx_ready, 1);
        check("rst_mid_done", tx.tx_done, 0);
        check("rst_mid_err", tx.tx_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It is the sending side of the keyboard link that `keyboard` receives on, and it runs on the same 50 MHz `clock50` domain. It sends one command byte, such as 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable), to the keyboard using the PS/2 request-to-send sequence, then reports whether the device acknowledged. The pads are open-collector: this block only ever pulls a line low or releases it.

## Interface
- `INHIBIT_CYCLES`, 5000: cycles the clock line is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1000000: limit on the whole device-clocked phase (20 ms).
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered `ps2_clk` level changes.
- `clk` in 1: 50 MHz system clock.
- `reset` in 1: reset, asynchronous and active-high.
- `tx_data` in 8: command byte, sampled on acceptance.
- `tx_valid` in 1: transmit request.
- `tx_ready` out 1: block is idle and can accept a request.
- `tx_done` out 1: one-cycle pulse when a transfer ends.
- `tx_err` out 1: valid during `tx_done`; 1 = no ACK or timeout.
- `busy` out 1: transfer in progress; the receiver must ignore the line while this is high.
- `ps2_clk_in` in 1: PS2_CLK pad level.
- `ps2_data_in` in 1: PS2_DAT pad level.
- `ps2_clk_oe` out 1: 1 pulls PS2_CLK low.
- `ps2_data_oe` out 1: 1 pulls PS2_DAT low.

## Operation
- **Input conditioning**
  - Both pad inputs pass through a 2-flop synchronizer.
  - `ps2_clk` is then glitch-filtered: the filtered level changes only after `FILTER_LEN` consecutive identical synchronized samples.
  - A falling edge (`fall`) is a filtered 1→0 transition.
- **IDLE**
  - Outputs: `tx_ready`=1, `busy`=0, both oe=0.
  - `tx_valid`&&`tx_ready` latches `tx_data`, computes odd parity (parity = ~^data) and moves to INHIBIT.
- **INHIBIT**
  - `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles; all `fall` events are ignored.
- **START**
  - One cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1.
  - Then release the clock (`ps2_clk_oe`=0) with the data line still low (start bit).
  - The timeout counter clears and starts counting at this point.
- **SHIFT**
  - Bit index n runs 0..9. On each `fall`, drive frame bit n: `ps2_data_oe` = ~bit.
  - Frame bits: n=0..7 are data LSB-first, n=8 is parity, n=9 is stop (oe=0).
  - After the stop bit, go to ACK.
- **ACK**
  - On the next `fall`, sample synchronized data. 0 = ACK, 1 = error.
  - Go to WAIT_IDLE.
- **WAIT_IDLE**
  - Wait until filtered clock and synchronized data are both 1.
  - Then pulse `tx_done` with `tx_err` = recorded error, and return to IDLE.
- **Timeout**
  - Applies from START through WAIT_IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`, release both lines the same cycle and pulse `tx_done` with `tx_err`=1 on the next cycle.
  - Return to IDLE. Any partial ACK result is discarded.
- **Busy and ignored requests**
  - `busy` = not IDLE.
  - `tx_valid` while not ready is ignored, not queued.
- **Reset** (asynchronous, including mid-transfer)
  - Returns to IDLE and releases both lines immediately.
  - All outputs take their reset values.
- **Counters**
  - Inhibit and timeout counters are sized with $clog2 of their parameters.
  - They never wrap; each clears on its state entry.

## Timing
- **Reset values:** `tx_ready`=1, `tx_done`=0, `tx_err`=0, `busy`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0.
- **Accept to clock pull:** `ps2_clk_oe` rises the cycle after acceptance; `tx_ready` falls the same cycle.
- **Inhibit length:** `ps2_clk_oe` stays high for `INHIBIT_CYCLES`+1 cycles, the last of which overlaps `ps2_data_oe`=1.
- **Pad edge to data change:** a `ps2_clk_in` falling edge reaches `fall` 2+`FILTER_LEN` cycles later. `ps2_data_oe` updates the cycle after `fall`, for 3+`FILTER_LEN` cycles total (11 at default). This is well inside the device's ≥5 µs setup window.
- **Done and err:** `tx_done` is high for exactly 1 cycle; `tx_err` holds its value until the next acceptance.
- **Back-to-back requests:** a new request can be accepted the cycle after `tx_done`.

## Test plan
- **Normal send with ACK**
  - Stimulus: send 0xED; device model clocks at 12.5 kHz and drives data low on the 11th falling edge.
  - Required: data bits sampled on rising edges are 0 (start), 1,0,1,1,0,1,1,1, 1 (parity), 1 (stop).
  - Required: `tx_done`=1 with `tx_err`=0, then `tx_ready`=1.
- **Parity check**
  - Stimulus: send 0x01.
  - Required: parity bit observed = 0. Send 0xFF: parity observed = 1.
- **No ACK**
  - Stimulus: device leaves data high on the 11th edge.
  - Required: `tx_done` with `tx_err`=1.
- **Timeout**
  - Stimulus: device never clocks.
  - Required: `ps2_data_oe` drops and `tx_done`/`tx_err`=1 at `TIMEOUT_CYCLES`+1 cycles after clock release.
- **Glitch filter and inhibit length**
  - Stimulus: 3-cycle low pulse on `ps2_clk_in` during SHIFT.
  - Required: no data change, and the bit index is unchanged.
  - Required: `ps2_clk_oe` high for exactly 5001 cycles after acceptance.
- **Reset mid-transfer and ignored request**
  - Stimulus: assert `reset` after the 4th falling edge.
  - Required: both oe go 0 with no clock edge needed, and `tx_ready`=1 after release.
  - Stimulus: `tx_valid` held during a transfer.
  - Required: exactly one transfer occurs.
